// File: rtl/bpred_pkg.sv
// Shared types and index helpers for the gshare/bimodal branch predictor.
// Helpers work on 64-bit zero-extended values; callers truncate to their own widths.
package bpred_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'd0,
    CtrWnt = 2'd1,
    CtrWt  = 2'd2,
    CtrSt  = 2'd3
  } ctr_e;

  localparam ctr_e PhtResetVal = CtrWnt;

  // Widest configuration the helpers support; real widths come from the top's parameters.
  localparam int unsigned MaxAddrW = 64;

  typedef struct packed {
    logic                valid;
    logic [MaxAddrW-1:0] tag;
    logic [MaxAddrW-1:0] target;
  } btb_entry_t;

  function automatic logic [63:0] low_mask(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] btb_index(input logic [63:0] pc, input int unsigned idx_w);
    return pc & low_mask(idx_w);
  endfunction

  function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> idx_w;
  endfunction

  function automatic logic [63:0] pht_index(input logic [63:0] pc, input logic [63:0] ghr,
                                            input int unsigned idx_w, input bit gshare);
    logic [63:0] base;
    base = pc & low_mask(idx_w);
    return gshare ? (base ^ ghr) : base;
  endfunction

endpackage

// File: rtl/bpred_gshare_if.sv
// Fetch-side prediction and resolve-side training signals of the branch predictor.
interface bpred_gshare_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned HIST_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] update_neip;
  logic [ADDR_W-1:0] update_target;
  logic              update_taken;
  logic              update_mispred;
  logic              update_valid;
  logic [ADDR_W-1:0] pred_target_curr;
  logic              pred_taken_curr;
  logic              pred_hit_curr;
  logic [HIST_W-1:0] ghr_out;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output pred_pc, update_neip, update_target, update_taken, update_mispred, update_valid,
    input  pred_target_curr, pred_taken_curr, pred_hit_curr, ghr_out, mispred_cnt
  );

  modport slave (
    input  pred_pc, update_neip, update_target, update_taken, update_mispred, update_valid,
    output pred_target_curr, pred_taken_curr, pred_hit_curr, ghr_out, mispred_cnt
  );
endinterface

// File: rtl/bpred_sat_ctr.sv
// N-bit saturating up/down counter next-state logic (combinational).
module bpred_sat_ctr #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] value_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    if (inc_i && !dec_i && (value_i != '1)) begin
      value_o = value_i + W'(1);
    end else if (dec_i && !inc_i && (value_i != '0)) begin
      value_o = value_i - W'(1);
    end
  end

endmodule

// File: rtl/bpred_gshare.sv
// Direct-mapped BTB plus 2-bit-counter PHT, indexed bimodally or by pc XOR global history.
// Prediction is combinational from state; training lands on the clock edge after resolve.
module bpred_gshare
  import bpred_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BTB_IDX_W  = 6,
  parameter int unsigned PHT_IDX_W  = 8,
  parameter int unsigned HIST_W     = 8,
  parameter int unsigned USE_GSHARE = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic          CLK,
  input logic          reset,
  bpred_gshare_if.slave bus
);

  localparam int unsigned TagW       = ADDR_W - BTB_IDX_W;
  localparam int unsigned BtbEntries = 1 << BTB_IDX_W;
  localparam int unsigned PhtEntries = 1 << PHT_IDX_W;
  localparam bit          Gshare     = (USE_GSHARE != 0);

  typedef struct packed {
    logic              valid;
    logic [TagW-1:0]   tag;
    logic [ADDR_W-1:0] target;
  } entry_t;

  entry_t            btb_q [BtbEntries];
  logic [1:0]        pht_q [PhtEntries];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0]  mispred_q, mispred_d;
  logic [1:0]        pht_d;

  logic [BTB_IDX_W-1:0] pred_bi, upd_bi;
  logic [PHT_IDX_W-1:0] pred_pi, upd_pi;
  logic [TagW-1:0]      pred_tag, upd_tag;
  entry_t               pred_entry;
  logic                 pred_hit;

  assign pred_bi  = BTB_IDX_W'(btb_index(64'(bus.pred_pc), BTB_IDX_W));
  assign pred_tag = TagW'(btb_tag(64'(bus.pred_pc), BTB_IDX_W));
  assign pred_pi  = PHT_IDX_W'(pht_index(64'(bus.pred_pc), 64'(ghr_q), PHT_IDX_W, Gshare));

  assign upd_bi  = BTB_IDX_W'(btb_index(64'(bus.update_neip), BTB_IDX_W));
  assign upd_tag = TagW'(btb_tag(64'(bus.update_neip), BTB_IDX_W));
  assign upd_pi  = PHT_IDX_W'(pht_index(64'(bus.update_neip), 64'(ghr_q), PHT_IDX_W, Gshare));

  assign pred_entry = btb_q[pred_bi];
  assign pred_hit   = pred_entry.valid && (pred_entry.tag == pred_tag);

  assign bus.pred_hit_curr    = pred_hit;
  assign bus.pred_target_curr = pred_hit ? pred_entry.target : '0;
  assign bus.pred_taken_curr  = pred_hit & pht_q[pred_pi][1];
  assign bus.ghr_out          = ghr_q;
  assign bus.mispred_cnt      = mispred_q;

  // Truncating cast shifts the oldest outcome out and also covers HIST_W == 1.
  assign ghr_d = HIST_W'({ghr_q, bus.update_taken});

  bpred_sat_ctr #(
    .W (2)
  ) u_pht_ctr (
    .value_i (pht_q[upd_pi]),
    .inc_i   (bus.update_taken),
    .dec_i   (!bus.update_taken),
    .value_o (pht_d)
  );

  bpred_sat_ctr #(
    .W (CNT_W)
  ) u_mispred_ctr (
    .value_i (mispred_q),
    .inc_i   (bus.update_valid & bus.update_mispred),
    .dec_i   (1'b0),
    .value_o (mispred_d)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < int'(BtbEntries); i++) begin
        btb_q[i].valid <= 1'b0;
      end
      for (int i = 0; i < int'(PhtEntries); i++) begin
        pht_q[i] <= PhtResetVal;
      end
      ghr_q     <= '0;
      mispred_q <= '0;
    end else if (bus.update_valid) begin
      pht_q[upd_pi] <= pht_d;
      if (bus.update_taken) begin
        btb_q[upd_bi] <= '{valid: 1'b1, tag: upd_tag, target: bus.update_target};
      end
      ghr_q     <= ghr_d;
      mispred_q <= mispred_d;
    end
  end

endmodule

// File: tb/tb_bpred_gshare.sv
// Directed bench: a bimodal instance (CNT_W=2) and a gshare instance, checked against
// hand-computed expectations.
module tb_bpred_gshare;

  logic CLK;
  logic reset;
  int   errors;
  int   checks;

  bpred_gshare_if #(.ADDR_W(32), .HIST_W(8), .CNT_W(2))  bb ();
  bpred_gshare_if #(.ADDR_W(32), .HIST_W(8), .CNT_W(16)) bg ();

  bpred_gshare #(
    .ADDR_W(32), .BTB_IDX_W(6), .PHT_IDX_W(8), .HIST_W(8), .USE_GSHARE(0), .CNT_W(2)
  ) dut_b (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bb)
  );

  bpred_gshare #(
    .ADDR_W(32), .BTB_IDX_W(6), .PHT_IDX_W(8), .HIST_W(8), .USE_GSHARE(1), .CNT_W(16)
  ) dut_g (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    reset = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  task automatic upd_b(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                       input logic mis);
    bb.update_neip    = pc;
    bb.update_target  = tgt;
    bb.update_taken   = tk;
    bb.update_mispred = mis;
    bb.update_valid   = 1'b1;
    @(posedge CLK);
    #1;
    bb.update_valid   = 1'b0;
  endtask

  task automatic upd_g(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    bg.update_neip    = pc;
    bg.update_target  = tgt;
    bg.update_taken   = tk;
    bg.update_mispred = 1'b0;
    bg.update_valid   = 1'b1;
    @(posedge CLK);
    #1;
    bg.update_valid   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bb.pred_pc = 32'd16;
    bg.pred_pc = 32'd16;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b0) begin
      errors++; $display("FAIL reset_hit: got %b want 0", bb.pred_hit_curr);
    end
    checks++;
    if (bb.pred_taken_curr !== 1'b0) begin
      errors++; $display("FAIL reset_taken: got %b want 0", bb.pred_taken_curr);
    end
    checks++;
    if (bb.pred_target_curr !== 32'd0) begin
      errors++; $display("FAIL reset_target: got %0d want 0", bb.pred_target_curr);
    end
    checks++;
    if (bb.ghr_out !== 8'd0 || bg.ghr_out !== 8'd0) begin
      errors++; $display("FAIL reset_ghr: got %0h/%0h want 0/0", bb.ghr_out, bg.ghr_out);
    end
    checks++;
    if (bb.mispred_cnt !== 2'd0 || bg.mispred_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", bb.mispred_cnt, bg.mispred_cnt);
    end
    checks++;
    if (bg.pred_hit_curr !== 1'b0 || bg.pred_target_curr !== 32'd0) begin
      errors++;
      $display("FAIL reset_g_pred: got hit=%b tgt=%0d want 0/0", bg.pred_hit_curr,
               bg.pred_target_curr);
    end
  endtask

  task automatic test_bimodal();
    do_reset();
    upd_b(32'd16, 32'd45, 1'b1, 1'b1);
    upd_b(32'd64, 32'd25, 1'b0, 1'b1);
    bb.pred_pc = 32'd16;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b1 || bb.pred_target_curr !== 32'd45 ||
        bb.pred_taken_curr !== 1'b1) begin
      errors++;
      $display("FAIL bim_pc16: got hit=%b tgt=%0d tk=%b want 1/45/1", bb.pred_hit_curr,
               bb.pred_target_curr, bb.pred_taken_curr);
    end
    bb.pred_pc = 32'd64;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b0 || bb.pred_target_curr !== 32'd0 ||
        bb.pred_taken_curr !== 1'b0) begin
      errors++;
      $display("FAIL bim_pc64: got hit=%b tgt=%0d tk=%b want 0/0/0", bb.pred_hit_curr,
               bb.pred_target_curr, bb.pred_taken_curr);
    end
    checks++;
    if (bb.mispred_cnt !== 2'd2) begin
      errors++; $display("FAIL bim_cnt: got %0d want 2", bb.mispred_cnt);
    end
    checks++;
    if (bb.ghr_out !== 8'b0000_0010) begin
      errors++; $display("FAIL bim_ghr: got %b want 00000010", bb.ghr_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) upd_b(32'd16, 32'd45, 1'b1, 1'b0);
    bb.pred_pc = 32'd16;
    #1;
    checks++;
    if (bb.pred_taken_curr !== 1'b1) begin
      errors++; $display("FAIL sat_st: got %b want 1", bb.pred_taken_curr);
    end
    upd_b(32'd16, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bb.pred_taken_curr !== 1'b1) begin
      errors++; $display("FAIL sat_st_to_wt: got %b want 1", bb.pred_taken_curr);
    end
    upd_b(32'd16, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bb.pred_taken_curr !== 1'b0 || bb.pred_hit_curr !== 1'b1 ||
        bb.pred_target_curr !== 32'd45) begin
      errors++;
      $display("FAIL sat_wt_to_wnt: got tk=%b hit=%b tgt=%0d want 0/1/45",
               bb.pred_taken_curr, bb.pred_hit_curr, bb.pred_target_curr);
    end
    checks++;
    if (bb.mispred_cnt !== 2'd0) begin
      errors++; $display("FAIL sat_cnt: got %0d want 0", bb.mispred_cnt);
    end
  endtask

  task automatic test_alias();
    do_reset();
    upd_b(32'd16, 32'd45, 1'b1, 1'b0);
    upd_b(32'd80, 32'd99, 1'b1, 1'b0);
    bb.pred_pc = 32'd16;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b0 || bb.pred_target_curr !== 32'd0) begin
      errors++;
      $display("FAIL alias_old: got hit=%b tgt=%0d want 0/0", bb.pred_hit_curr,
               bb.pred_target_curr);
    end
    bb.pred_pc = 32'd80;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b1 || bb.pred_target_curr !== 32'd99 ||
        bb.pred_taken_curr !== 1'b1) begin
      errors++;
      $display("FAIL alias_new: got hit=%b tgt=%0d tk=%b want 1/99/1", bb.pred_hit_curr,
               bb.pred_target_curr, bb.pred_taken_curr);
    end
  endtask

  task automatic test_gshare();
    logic tk_hist6;
    do_reset();
    upd_g(32'd16, 32'd45, 1'b1);
    upd_g(32'd16, 32'd45, 1'b1);
    upd_g(32'd16, 32'd45, 1'b0);
    checks++;
    if (bg.ghr_out !== 8'b0000_0110) begin
      errors++; $display("FAIL gsh_ghr: got %b want 00000110", bg.ghr_out);
    end
    // ghr=6 selects PHT[22], still weakly not-taken.
    bg.pred_pc = 32'd16;
    #1;
    tk_hist6 = bg.pred_taken_curr;
    checks++;
    if (tk_hist6 !== 1'b0 || bg.pred_hit_curr !== 1'b1) begin
      errors++;
      $display("FAIL gsh_hist6: got tk=%b hit=%b want 0/1", tk_hist6, bg.pred_hit_curr);
    end
    // Shift zeros in via an unrelated pc until ghr returns to 0, selecting PHT[16].
    for (int i = 0; i < 8; i++) upd_g(32'd100, 32'd0, 1'b0);
    checks++;
    if (bg.ghr_out !== 8'd0) begin
      errors++; $display("FAIL gsh_ghr_zero: got %b want 00000000", bg.ghr_out);
    end
    checks++;
    if (bg.pred_taken_curr !== 1'b1 || bg.pred_taken_curr === tk_hist6) begin
      errors++;
      $display("FAIL gsh_hist0: got tk=%b want 1 (history 6 gave %b)", bg.pred_taken_curr,
               tk_hist6);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bb.pred_pc        = 32'd16;
    bb.update_neip    = 32'd16;
    bb.update_target  = 32'd45;
    bb.update_taken   = 1'b1;
    bb.update_mispred = 1'b0;
    bb.update_valid   = 1'b1;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b0 || bb.pred_taken_curr !== 1'b0) begin
      errors++;
      $display("FAIL same_pre: got hit=%b tk=%b want 0/0", bb.pred_hit_curr,
               bb.pred_taken_curr);
    end
    @(posedge CLK);
    #1;
    bb.update_valid = 1'b0;
    checks++;
    if (bb.pred_hit_curr !== 1'b1 || bb.pred_taken_curr !== 1'b1 ||
        bb.pred_target_curr !== 32'd45) begin
      errors++;
      $display("FAIL same_post: got hit=%b tk=%b tgt=%0d want 1/1/45", bb.pred_hit_curr,
               bb.pred_taken_curr, bb.pred_target_curr);
    end
  endtask

  task automatic test_reset_wins();
    do_reset();
    upd_b(32'd16, 32'd45, 1'b1, 1'b1);
    bb.update_neip    = 32'd16;
    bb.update_target  = 32'd45;
    bb.update_taken   = 1'b1;
    bb.update_mispred = 1'b1;
    bb.update_valid   = 1'b1;
    reset             = 1'b0;
    @(posedge CLK);
    #1;
    reset           = 1'b1;
    bb.update_valid = 1'b0;
    bb.pred_pc      = 32'd16;
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b0 || bb.pred_taken_curr !== 1'b0 ||
        bb.pred_target_curr !== 32'd0 || bb.ghr_out !== 8'd0 || bb.mispred_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_wins: got hit=%b tk=%b tgt=%0d ghr=%0h cnt=%0d want all 0",
               bb.pred_hit_curr, bb.pred_taken_curr, bb.pred_target_curr, bb.ghr_out,
               bb.mispred_cnt);
    end
    // Counter back at WNT: one taken gives WT, one not-taken drops to WNT.
    upd_b(32'd16, 32'd45, 1'b1, 1'b0);
    upd_b(32'd16, 32'd45, 1'b0, 1'b0);
    checks++;
    if (bb.pred_taken_curr !== 1'b0 || bb.pred_hit_curr !== 1'b1) begin
      errors++;
      $display("FAIL rst_pht: got tk=%b hit=%b want 0/1", bb.pred_taken_curr,
               bb.pred_hit_curr);
    end
  endtask

  task automatic test_no_valid();
    do_reset();
    bb.pred_pc        = 32'd16;
    bb.update_neip    = 32'd16;
    bb.update_target  = 32'd45;
    bb.update_taken   = 1'b1;
    bb.update_mispred = 1'b1;
    bb.update_valid   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bb.pred_hit_curr !== 1'b0 || bb.ghr_out !== 8'd0 || bb.mispred_cnt !== 2'd0) begin
      errors++;
      $display("FAIL no_valid: got hit=%b ghr=%0h cnt=%0d want 0/0/0", bb.pred_hit_curr,
               bb.ghr_out, bb.mispred_cnt);
    end
  endtask

  task automatic test_cnt_saturate();
    do_reset();
    for (int i = 0; i < 3; i++) upd_b(32'd64, 32'd0, 1'b0, 1'b1);
    checks++;
    if (bb.mispred_cnt !== 2'd3) begin
      errors++; $display("FAIL cnt_three: got %0d want 3", bb.mispred_cnt);
    end
    for (int i = 0; i < 2; i++) upd_b(32'd64, 32'd0, 1'b0, 1'b1);
    checks++;
    if (bb.mispred_cnt !== 2'd3) begin
      errors++; $display("FAIL cnt_sat: got %0d want 3", bb.mispred_cnt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bb.pred_pc = '0; bb.update_neip = '0; bb.update_target = '0;
    bb.update_taken = 1'b0; bb.update_mispred = 1'b0; bb.update_valid = 1'b0;
    bg.pred_pc = '0; bg.update_neip = '0; bg.update_target = '0;
    bg.update_taken = 1'b0; bg.update_mispred = 1'b0; bg.update_valid = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_bimodal();
    test_saturation();
    test_alias();
    test_gshare();
    test_same_cycle();
    test_reset_wins();
    test_no_valid();
    test_cnt_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
